// File: rtl/svm_mem_xfer_if.sv
// svm_mem_xfer_if
//   Groups the DMA request/return signals used by svm_mem_xfer.
//   master : the transfer engine (issues requests, consumes read returns)
//   slave  : the memory/DMA side (accepts requests, produces read returns)
//
//   mem_dma_rdy          slave -> master  DMA accepts the current request
//   mem_dma_req_vld      master -> slave  request valid
//   mem_dma_rdbar_wr     master -> slave  0 = read, 1 = write
//   mem_dma_req_addr     master -> slave  byte address
//   mem_dma_req_data     master -> slave  write data
//   mem_dma_rd_data      slave -> master  read return data (in request order)
//   mem_dma_rd_data_vld  slave -> master  read return valid
interface svm_mem_xfer_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          mem_dma_rdy;
    logic          mem_dma_req_vld;
    logic          mem_dma_rdbar_wr;
    logic [AW-1:0] mem_dma_req_addr;
    logic [DW-1:0] mem_dma_req_data;
    logic [DW-1:0] mem_dma_rd_data;
    logic          mem_dma_rd_data_vld;

    modport master (
        input  mem_dma_rdy,
        output mem_dma_req_vld,
        output mem_dma_rdbar_wr,
        output mem_dma_req_addr,
        output mem_dma_req_data,
        input  mem_dma_rd_data,
        input  mem_dma_rd_data_vld
    );

    modport slave (
        output mem_dma_rdy,
        input  mem_dma_req_vld,
        input  mem_dma_rdbar_wr,
        input  mem_dma_req_addr,
        input  mem_dma_req_data,
        output mem_dma_rd_data,
        output mem_dma_rd_data_vld
    );
endinterface

// File: rtl/svm_mem_xfer.sv
// svm_mem_xfer
//   Moves weights / data points from memory into the SVM array register
//   lanes and writes single result words back to memory.
//
//   clk, rst_n        single clock, synchronous active-low reset
//   cmd_vld/cmd_rdy   command handshake (cmd_rdy only while idle)
//   cmd               0 NOP/illegal, 1 LOAD_WEIGHTS, 2 LOAD_POINT, 3 WRITE_RESULT
//   cmd_base          byte base address
//   cmd_len           beat count for loads (1..NUM_LANES)
//   cmd_wdata         write data for WRITE_RESULT
//   dma               DMA request/return bus (master side)
//   arr_reg_*         registered array write: data, weight flag, lane, strobe
//   mem_resp/_vld     response code (DONE/ERR_LEN/ERR_CMD/ERR_SPUR) + 1-cycle pulse
module svm_mem_xfer #(
    parameter int  DW        = 32,
    parameter int  AW        = 32,
    parameter int  NUM_LANES = 32,
    parameter int  MAX_OUT   = 4,
    localparam int PW        = $clog2(NUM_LANES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_vld,
    input  logic [1:0]       cmd,
    input  logic [AW-1:0]    cmd_base,
    input  logic [PW:0]      cmd_len,
    input  logic [DW-1:0]    cmd_wdata,
    output logic             cmd_rdy,
    svm_mem_xfer_if.master   dma,
    output logic [DW-1:0]    arr_reg_data,
    output logic             arr_wghtbar_data,
    output logic [PW-1:0]    arr_reg_pos,
    output logic             arr_reg_data_vld,
    output logic [2:0]       mem_resp,
    output logic             mem_resp_vld
);

    localparam int LW    = PW + 1;
    localparam int OW    = $clog2(MAX_OUT + 1);
    localparam int BYTES = DW / 8;

    localparam logic [2:0] RESP_DONE     = 3'b001;
    localparam logic [2:0] RESP_ERR_LEN  = 3'b010;
    localparam logic [2:0] RESP_ERR_CMD  = 3'b011;
    localparam logic [2:0] RESP_ERR_SPUR = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_DRAIN,
        S_WR_REQ,
        S_RESP
    } state_e;

    state_e        state_q, state_d;
    logic          en_q, en_d;             // 0 while in reset, gates cmd_rdy
    logic [AW-1:0] base_q, base_d;
    logic [LW-1:0] len_q, len_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          wght_q, wght_d;
    logic [LW-1:0] issued_q, issued_d;
    logic [LW-1:0] received_q, received_d;
    logic [OW-1:0] outst_q, outst_d;
    logic          spur_q, spur_d;
    logic [2:0]    resp_q, resp_d;
    logic          arr_vld_q, arr_vld_d;
    logic [DW-1:0] arr_data_q, arr_data_d;
    logic [PW-1:0] arr_pos_q, arr_pos_d;
    logic          arr_wght_q, arr_wght_d;

    logic          rd_state;
    logic          rd_issue;
    logic          wr_issue;
    logic          req_acc;
    logic          rd_acc;
    logic          ret_ok;
    logic          ret_spur;
    logic          len_ok;
    logic [AW-1:0] rd_addr;
    logic [2:0]    done_code;

    assign rd_state = (state_q == S_RD_REQ) || (state_q == S_RD_DRAIN);
    assign rd_issue = (state_q == S_RD_REQ) && (issued_q < len_q) &&
                      (outst_q < OW'(MAX_OUT));
    assign wr_issue = (state_q == S_WR_REQ);
    assign req_acc  = dma.mem_dma_req_vld && dma.mem_dma_rdy;
    assign rd_acc   = rd_issue && dma.mem_dma_rdy;

    // A return is only genuine while a read is actually in flight.
    assign ret_ok   = dma.mem_dma_rd_data_vld && rd_state && (outst_q != '0);
    assign ret_spur = dma.mem_dma_rd_data_vld && !ret_ok;

    assign len_ok   = (cmd_len != '0) && (cmd_len <= LW'(NUM_LANES));

    // Address wraps modulo 2^AW by truncation of the sum.
    assign rd_addr  = base_q + AW'(issued_q) * AW'(BYTES);

    // A spurious return seen in the very cycle of completion still counts.
    assign done_code = (spur_q || ret_spur) ? RESP_ERR_SPUR : RESP_DONE;

    assign dma.mem_dma_req_vld  = rd_issue || wr_issue;
    assign dma.mem_dma_rdbar_wr = wr_issue;
    assign dma.mem_dma_req_addr = wr_issue ? base_q : (rd_issue ? rd_addr : '0);
    assign dma.mem_dma_req_data = wr_issue ? wdata_q : '0;

    assign cmd_rdy          = en_q && (state_q == S_IDLE);
    assign mem_resp         = resp_q;
    assign mem_resp_vld     = (state_q == S_RESP);
    assign arr_reg_data     = arr_data_q;
    assign arr_wghtbar_data = arr_wght_q;
    assign arr_reg_pos      = arr_pos_q;
    assign arr_reg_data_vld = arr_vld_q;

    always_comb begin
        state_d    = state_q;
        en_d       = 1'b1;
        base_d     = base_q;
        len_d      = len_q;
        wdata_d    = wdata_q;
        wght_d     = wght_q;
        issued_d   = issued_q;
        received_d = received_q;
        outst_d    = outst_q;
        spur_d     = spur_q | ret_spur;
        resp_d     = resp_q;
        arr_vld_d  = ret_ok;
        arr_data_d = arr_data_q;
        arr_pos_d  = arr_pos_q;
        arr_wght_d = arr_wght_q;

        // Array write path: registered one cycle behind the return.
        if (ret_ok) begin
            arr_data_d = dma.mem_dma_rd_data;
            arr_pos_d  = received_q[PW-1:0];
            arr_wght_d = wght_q;
            received_d = received_q + LW'(1);
        end

        if (rd_acc) begin
            issued_d = issued_q + LW'(1);
        end

        // Simultaneous accept and return cancel out.
        case ({rd_acc, ret_ok})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (cmd_vld && cmd_rdy) begin
                    base_d     = cmd_base;
                    len_d      = cmd_len;
                    wdata_d    = cmd_wdata;
                    wght_d     = (cmd == 2'd1);
                    issued_d   = '0;
                    received_d = '0;
                    case (cmd)
                        2'd1, 2'd2: begin
                            if (len_ok) begin
                                state_d = S_RD_REQ;
                            end else begin
                                state_d = S_RESP;
                                resp_d  = RESP_ERR_LEN;
                                spur_d  = 1'b0;
                            end
                        end
                        2'd3: begin
                            state_d = S_WR_REQ;
                        end
                        default: begin
                            state_d = S_RESP;
                            resp_d  = RESP_ERR_CMD;
                            spur_d  = 1'b0;
                        end
                    endcase
                end
            end
            S_RD_REQ: begin
                // All returns may already be in when issuing finishes.
                if (issued_q == len_q) begin
                    if (received_q == len_q) begin
                        state_d = S_RESP;
                        resp_d  = done_code;
                        spur_d  = 1'b0;
                    end else begin
                        state_d = S_RD_DRAIN;
                    end
                end
            end
            S_RD_DRAIN: begin
                if (received_q == len_q) begin
                    state_d = S_RESP;
                    resp_d  = done_code;
                    spur_d  = 1'b0;
                end
            end
            S_WR_REQ: begin
                if (req_acc) begin
                    state_d = S_RESP;
                    resp_d  = done_code;
                    spur_d  = 1'b0;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            en_q       <= 1'b0;
            base_q     <= '0;
            len_q      <= '0;
            wdata_q    <= '0;
            wght_q     <= 1'b0;
            issued_q   <= '0;
            received_q <= '0;
            outst_q    <= '0;
            spur_q     <= 1'b0;
            resp_q     <= '0;
            arr_vld_q  <= 1'b0;
            arr_data_q <= '0;
            arr_pos_q  <= '0;
            arr_wght_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            base_q     <= base_d;
            len_q      <= len_d;
            wdata_q    <= wdata_d;
            wght_q     <= wght_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            outst_q    <= outst_d;
            spur_q     <= spur_d;
            resp_q     <= resp_d;
            arr_vld_q  <= arr_vld_d;
            arr_data_q <= arr_data_d;
            arr_pos_q  <= arr_pos_d;
            arr_wght_q <= arr_wght_d;
        end
    end

endmodule

// File: tb/tb_svm_mem_xfer.sv
// tb_svm_mem_xfer
//   Scoreboard bench for svm_mem_xfer: expected DMA requests, array writes
//   and responses are queued when a command is driven and popped as the
//   DUT produces them. A small DMA model returns read data in order.
module tb_svm_mem_xfer;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int NL  = 32;
    localparam int MO  = 4;
    localparam int PW  = 5;
    localparam int LAT = 3;

    localparam logic [2:0] R_DONE = 3'b001;
    localparam logic [2:0] R_LEN  = 3'b010;
    localparam logic [2:0] R_CMD  = 3'b011;
    localparam logic [2:0] R_SPUR = 3'b100;

    typedef struct { logic [31:0] addr; logic wr; logic [31:0] data; } req_t;
    typedef struct { logic [31:0] data; logic [4:0] pos; logic w; } arr_t;
    typedef struct { logic [31:0] data; int due; } ret_t;
    typedef struct { logic [2:0] code; logic load; } rsp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_vld;
    logic [1:0]    cmd;
    logic [AW-1:0] cmd_base;
    logic [PW:0]   cmd_len;
    logic [DW-1:0] cmd_wdata;
    logic          cmd_rdy;
    logic [DW-1:0] arr_reg_data;
    logic          arr_wghtbar_data;
    logic [PW-1:0] arr_reg_pos;
    logic          arr_reg_data_vld;
    logic [2:0]    mem_resp;
    logic          mem_resp_vld;

    svm_mem_xfer_if #(.DW(DW), .AW(AW)) dma ();

    svm_mem_xfer #(.DW(DW), .AW(AW), .NUM_LANES(NL), .MAX_OUT(MO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_vld          (cmd_vld),
        .cmd              (cmd),
        .cmd_base         (cmd_base),
        .cmd_len          (cmd_len),
        .cmd_wdata        (cmd_wdata),
        .cmd_rdy          (cmd_rdy),
        .dma              (dma),
        .arr_reg_data     (arr_reg_data),
        .arr_wghtbar_data (arr_wghtbar_data),
        .arr_reg_pos      (arr_reg_pos),
        .arr_reg_data_vld (arr_reg_data_vld),
        .mem_resp         (mem_resp),
        .mem_resp_vld     (mem_resp_vld)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   rd_acc = 0;
    int   nxt_pos = 0;
    int   last_strobe = -10;
    logic cur_w = 1'b0;
    logic hold = 1'b0;
    logic stray_req = 1'b0;
    logic rdy_force = 1'b1;
    logic rdy_rand = 1'b0;

    req_t exp_req[$];
    arr_t exp_arr[$];
    ret_t ret_q[$];
    rsp_t exp_rsp[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // DMA model: drives rdy and in-order read returns just after each edge.
    initial begin
        dma.mem_dma_rdy         = 1'b0;
        dma.mem_dma_rd_data     = '0;
        dma.mem_dma_rd_data_vld = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            dma.mem_dma_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
            if (stray_req) begin
                dma.mem_dma_rd_data_vld = 1'b1;
                dma.mem_dma_rd_data     = 32'hBAD0_BAD0;
                stray_req               = 1'b0;
            end else if (!hold && ret_q.size() > 0 && ret_q[0].due <= cyc) begin
                dma.mem_dma_rd_data_vld = 1'b1;
                dma.mem_dma_rd_data     = ret_q[0].data;
                void'(ret_q.pop_front());
            end else begin
                dma.mem_dma_rd_data_vld = 1'b0;
            end
        end
    end

    // Monitor: compares DUT activity against the scoreboard queues.
    initial begin
        req_t r;
        ret_t rt;
        arr_t a;
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (dma.mem_dma_req_vld && dma.mem_dma_rdy) begin
                    if (exp_req.size() == 0) begin
                        chk("req_unexpected", 64'(dma.mem_dma_req_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        r = exp_req.pop_front();
                        chk("req_addr", 64'(dma.mem_dma_req_addr), 64'(r.addr));
                        chk("req_wr", 64'(dma.mem_dma_rdbar_wr), 64'(r.wr));
                        if (r.wr) begin
                            chk("req_data", 64'(dma.mem_dma_req_data), 64'(r.data));
                        end else begin
                            rd_acc++;
                            rt.data = $urandom;
                            rt.due  = cyc + LAT;
                            ret_q.push_back(rt);
                            a.data = rt.data;
                            a.pos  = 5'(nxt_pos);
                            a.w    = cur_w;
                            nxt_pos++;
                            exp_arr.push_back(a);
                        end
                    end
                end
                if (arr_reg_data_vld) begin
                    if (exp_arr.size() == 0) begin
                        chk("arr_unexpected", 64'(arr_reg_pos), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        a = exp_arr.pop_front();
                        chk("arr_data", 64'(arr_reg_data), 64'(a.data));
                        chk("arr_pos", 64'(arr_reg_pos), 64'(a.pos));
                        chk("arr_wght", 64'(arr_wghtbar_data), 64'(a.w));
                    end
                    last_strobe = cyc;
                end
                if (mem_resp_vld) begin
                    if (exp_rsp.size() == 0) begin
                        chk("resp_unexpected", 64'(mem_resp), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_rsp.pop_front();
                        chk("resp_code", 64'(mem_resp), 64'(e.code));
                        if (e.load && e.code == R_DONE)
                            chk("done_latency", 64'(cyc), 64'(last_strobe + 1));
                    end
                end
            end
        end
    end

    task automatic send_cmd(input logic [1:0] c, input logic [31:0] base,
                            input int len, input logic [31:0] wd);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_rdy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_rdy) chk("cmd_rdy_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        cmd_vld   = 1'b1;
        cmd       = c;
        cmd_base  = base;
        cmd_len   = 6'(len);
        cmd_wdata = wd;
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
    endtask

    task automatic load_cmd(input logic [1:0] c, input logic [31:0] base,
                            input int len, input logic [2:0] code);
        req_t r;
        rsp_t e;
        for (int i = 0; i < len; i++) begin
            r.addr = base + 32'(i * 4);
            r.wr   = 1'b0;
            r.data = '0;
            exp_req.push_back(r);
        end
        e.code = code;
        e.load = 1'b1;
        exp_rsp.push_back(e);
        cur_w   = (c == 2'd1);
        nxt_pos = 0;
        rd_acc  = 0;
        send_cmd(c, base, len, 32'h0);
    endtask

    task automatic err_cmd(input logic [1:0] c, input int len, input logic [2:0] code);
        rsp_t e;
        e.code = code;
        e.load = 1'b0;
        exp_rsp.push_back(e);
        send_cmd(c, 32'h500, len, 32'h0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(exp_rsp.size() == 0 && cmd_rdy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("idle_timeout", 64'(0), 64'(1));
        chk("req_leftover", 64'(exp_req.size()), 64'(0));
        chk("arr_leftover", 64'(exp_arr.size()), 64'(0));
        exp_req.delete();
        exp_arr.delete();
        exp_rsp.delete();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_cmd_rdy"}, 64'(cmd_rdy), 64'(0));
        chk({tag, "_req_vld"}, 64'(dma.mem_dma_req_vld), 64'(0));
        chk({tag, "_req_addr"}, 64'(dma.mem_dma_req_addr), 64'(0));
        chk({tag, "_arr_vld"}, 64'(arr_reg_data_vld), 64'(0));
        chk({tag, "_arr_data"}, 64'(arr_reg_data), 64'(0));
        chk({tag, "_resp"}, 64'(mem_resp), 64'(0));
        chk({tag, "_resp_vld"}, 64'(mem_resp_vld), 64'(0));
    endtask

    initial begin
        req_t r;
        rsp_t e;
        int   n;
        rst_n     = 1'b0;
        cmd_vld   = 1'b0;
        cmd       = '0;
        cmd_base  = '0;
        cmd_len   = '0;
        cmd_wdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("cmd_rdy_after_reset", 64'(cmd_rdy), 64'(1));

        // Weight load, fixed latency, continuous rdy
        load_cmd(2'd1, 32'h100, 4, R_DONE);
        wait_idle();

        // Point load with returns withheld: issuing stalls at MAX_OUT
        hold = 1'b1;
        load_cmd(2'd2, 32'h4000, 6, R_DONE);
        repeat (12) @(negedge clk);
        chk("outst_issued", 64'(rd_acc), 64'(MO));
        chk("outst_req_vld", 64'(dma.mem_dma_req_vld), 64'(0));
        hold = 1'b0;
        wait_idle();

        // Illegal lengths and command: response only, no DMA traffic
        err_cmd(2'd1, 0, R_LEN);
        wait_idle();
        err_cmd(2'd2, NL + 1, R_LEN);
        wait_idle();
        err_cmd(2'd0, 4, R_CMD);
        wait_idle();

        // Write with rdy held low: request must stay stable
        rdy_force = 1'b0;
        repeat (2) @(posedge clk);
        r.addr = 32'h2000;
        r.wr   = 1'b1;
        r.data = 32'hDEAD_BEEF;
        exp_req.push_back(r);
        e.code = R_DONE;
        e.load = 1'b0;
        exp_rsp.push_back(e);
        send_cmd(2'd3, 32'h2000, 0, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("wr_hold_vld", 64'(dma.mem_dma_req_vld), 64'(1));
            chk("wr_hold_addr", 64'(dma.mem_dma_req_addr), 64'h2000);
            chk("wr_hold_data", 64'(dma.mem_dma_req_data), 64'hDEAD_BEEF);
            chk("wr_hold_type", 64'(dma.mem_dma_rdbar_wr), 64'(1));
        end
        rdy_force = 1'b1;
        wait_idle();

        // Stray return while idle poisons the next load's response
        stray_req = 1'b1;
        repeat (3) @(posedge clk);
        load_cmd(2'd2, 32'h300, 1, R_SPUR);
        wait_idle();

        // Full-length load with random DMA back-pressure
        rdy_rand = 1'b1;
        load_cmd(2'd1, 32'h8000, NL, R_DONE);
        wait_idle();
        rdy_rand = 1'b0;

        // Address wrap past 2^AW
        load_cmd(2'd2, 32'hFFFF_FFF8, 4, R_DONE);
        wait_idle();

        // Reset during drain with two reads in flight
        hold = 1'b1;
        load_cmd(2'd2, 32'h600, 2, R_DONE);
        n = 0;
        while (rd_acc < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_reads_issued", 64'(rd_acc), 64'(2));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_req.delete();
        exp_arr.delete();
        exp_rsp.delete();
        ret_q.delete();
        hold = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("midreset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("cmd_rdy_after_midreset", 64'(cmd_rdy), 64'(1));
        repeat (6) @(negedge clk);

        // Normal operation after the abandoned transfer
        load_cmd(2'd1, 32'h700, 2, R_DONE);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
